// File: rtl/timer_mmss.sv
// Microwave M:SS countdown stage: shifts in keypad digits in load mode and
// decrements once per synchronized 1 Hz edge in count mode.
module timer_mmss #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic [3:0]             nxt_so, nxt_st, nxt_mo;
  logic                   nxt_done;

  // Edge detect on the synchronized level, so a held-high input fires only once.
  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    nxt_so   = sec_ones;
    nxt_st   = sec_tens;
    nxt_mo   = min_ones;
    nxt_done = 1'b0;
    if (tick) begin
      if (!enablen) begin
        if (!loadn && D <= 4'd9) begin
          nxt_mo = sec_tens;
          nxt_st = sec_ones;
          nxt_so = D;
        end
      end else if (!zero) begin
        if (sec_ones != 4'd0) begin
          nxt_so = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
          nxt_so = 4'd9;
          nxt_st = sec_tens - 4'd1;
        end else begin
          nxt_so = 4'd9;
          nxt_st = 4'd5;
          nxt_mo = min_ones - 4'd1;
        end
        nxt_done = (nxt_so == 4'd0) && (nxt_st == 4'd0) && (nxt_mo == 4'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      zero     <= 1'b1;
      done     <= 1'b0;
    end else begin
      sync_q[0] <= pgt_1Hz;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q   <= sync_q[SYNC_STAGES-1];
      sec_ones <= nxt_so;
      sec_tens <= nxt_st;
      min_ones <= nxt_mo;
      // Registered alongside the digits so it always matches them.
      zero     <= (nxt_so == 4'd0) && (nxt_st == 4'd0) && (nxt_mo == 4'd0);
      done     <= nxt_done;
    end
  end

endmodule

// File: doc/timer_mmss.md
Name: timer_mmss

Overview:
Countdown timer stage directly downstream of the numpad encoder in the microwave oven datapath. In load mode it shifts encoder BCD digits into an M:SS register, one digit per key press. In count mode it decrements M:SS once per 1 Hz pulse and flags completion. All logic runs on the single system clock; pgt_1Hz is sampled as data, never used as a clock.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pgt_1Hz synchronizer (must be >= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
clear  input  1  synchronous active-high reset
D  input  4  BCD digit from encoder; values 10..15 are invalid
loadn  input  1  active-low key-pressed flag from encoder
pgt_1Hz  input  1  encoder pulse output: debounced key strobe in load mode, 1 Hz in count mode
enablen  input  1  mode select, same net as encoder enablen; 0 = load mode, 1 = count mode
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes
zero  output  1  high when sec_ones, sec_tens and min_ones are all 0
done  output  1  one-cycle pulse when count mode reaches 0:00 from a nonzero value

Behaviour:
- Reset (clear=1 at a rising clk edge): sec_ones=sec_tens=min_ones=0, zero=1, done=0, synchronizer and edge-detect registers=0. Clear overrides every other input in that cycle.
- pgt_1Hz passes through a SYNC_STAGES-deep flip-flop chain followed by one edge-detect register. tick=1 for exactly one clk cycle per 0->1 transition. Latency from the pgt_1Hz rise to the register update is SYNC_STAGES+1 cycles.
- tick is ignored unless pgt_1Hz has been low for at least one synchronized sample, so a level held high never retriggers.
- Load mode (enablen=0), on tick with loadn=0 and D<=9: shift left, with min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - The old min_ones is discarded, which gives natural overflow of a fourth digit.
  - D>9 or loadn=1 at tick: no change.
  - Digit values are sampled in the tick cycle and are not latched earlier.
- sec_tens may legally hold 6..9 after loading (e.g. 1:75). No clamping is applied; the countdown handles it.
- Count mode (enablen=1), on tick:
  - If zero=1: no change, no done.
  - Else decrement in BCD:
    - sec_ones>0: sec_ones-1.
    - sec_ones=0 and sec_tens>0: sec_ones=9, sec_tens-1.
    - sec_ones=0 and sec_tens=0: sec_ones=9, sec_tens=5, min_ones-1.
  - If the new value is 0:00, done=1 in the following cycle only.
- zero is registered and updated in the same cycle as the digit registers. It is never stale for more than 0 cycles relative to the digits.
- Mode change mid-operation: the digit registers hold. A tick already in flight in the sync chain is applied under the enablen value present in the tick cycle.
- Simultaneous clear and tick: clear wins and the tick is lost.
- No ports or states other than those listed. Each digit register only ever holds 0..9.

Test Plan:
- Reset: assert clear for 2 cycles with pgt_1Hz toggling -> all digits 0, zero=1, done=0 throughout; first tick after release is the only one processed.
- Load: enablen=0, key presses D=1, 3, 0 (loadn=0, pgt_1Hz pulse each) -> min_ones=1, sec_tens=3, sec_ones=0 after the third pulse, each update exactly SYNC_STAGES+1 cycles after the pgt_1Hz rise; a fourth press D=5 -> 3:05.
- Invalid/ignored: D=4'hC with loadn=0, then D=7 with loadn=1, each with a pulse -> digits unchanged; pgt_1Hz held high for 50 cycles -> single shift only.
- Countdown with borrow: load 1:00, enablen=1, 3 ticks -> 0:59, 0:58, 0:57. Load 1:75 and tick 76 times -> 0:59.
- Completion: load 0:02, enablen=1, 4 ticks -> 0:01, 0:00 with done high for exactly one cycle; ticks 3 and 4 leave 0:00, zero=1, done=0.
- Mid-operation: at 0:30 in count mode switch enablen=0 and press D=4 -> 3:04; clear pulse asserted during a tick cycle -> 0:00 and no decrement.
